// File: rtl/pattern_checker_pkg.sv
// Shared types and constants for the serial pattern checker.
package pattern_checker_pkg;

  typedef enum logic {HUNT, LOCKED} chk_state_t;

  localparam int unsigned     ERR_W   = 8;
  localparam logic [ERR_W-1:0] ERR_MAX = 8'hFF;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; a synchronous clear wins over a simultaneous increment.
module sat_counter #(
  parameter int unsigned   W   = 8,
  parameter logic [W-1:0]  MAX = '1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != MAX)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/pattern_checker.sv
// Serial receive-side checker: hunts for alignment to a repeating pattern,
// locks, then flags per-bit errors, clean frames and a saturating error count.
module pattern_checker
  import pattern_checker_pkg::*;
#(
  parameter logic [31:0] PATTERN     = 32'b1011_0010,
  parameter int unsigned LEN         = 8,
  parameter int unsigned LOSS_THRESH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             y,
  input  logic             clr_err,
  output logic             locked,
  output logic             bit_err,
  output logic             frame_ok,
  output logic [ERR_W-1:0] err_count
);

  localparam int unsigned FW = $clog2(LEN + 1);
  localparam int unsigned PW = $clog2(LEN);

  localparam logic [LEN-1:0] PAT       = PATTERN[LEN-1:0];
  localparam logic [FW-1:0]  FILL_MAX  = FW'(LEN);
  localparam logic [FW-1:0]  FILL_LAST = FW'(LEN - 1);
  localparam logic [PW-1:0]  LAST_P    = PW'(LEN - 1);
  localparam logic [3:0]     THRESH    = 4'(LOSS_THRESH);

  chk_state_t     state, state_n;
  // Only LEN-1 bits of history are stored; the live bit completes the window.
  logic [LEN-2:0] sr, sr_n;
  logic [FW-1:0]  fill, fill_n;
  logic [PW-1:0]  phase, phase_n;
  logic [3:0]     consec, consec_n;
  logic           frame_bad, frame_bad_n;
  logic           bit_err_n, frame_ok_n;
  logic           mismatch;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= HUNT;
      sr        <= '0;
      fill      <= '0;
      phase     <= '0;
      consec    <= '0;
      frame_bad <= 1'b0;
      bit_err   <= 1'b0;
      frame_ok  <= 1'b0;
    end else begin
      state     <= state_n;
      sr        <= sr_n;
      fill      <= fill_n;
      phase     <= phase_n;
      consec    <= consec_n;
      frame_bad <= frame_bad_n;
      bit_err   <= bit_err_n;
      frame_ok  <= frame_ok_n;
    end
  end

  always_comb begin
    state_n     = state;
    sr_n        = sr;
    fill_n      = fill;
    phase_n     = phase;
    consec_n    = consec;
    frame_bad_n = frame_bad;
    bit_err_n   = 1'b0;
    frame_ok_n  = 1'b0;
    mismatch    = 1'b0;

    unique case (state)
      HUNT: begin
        sr_n = {sr[LEN-3:0], y};
        if (fill != FILL_MAX) begin
          fill_n = fill + 1'b1;
        end
        if ((fill >= FILL_LAST) && ({sr, y} == PAT)) begin
          state_n     = LOCKED;
          phase_n     = '0;
          consec_n    = '0;
          frame_bad_n = 1'b0;
        end
      end

      LOCKED: begin
        mismatch    = (y != PAT[LAST_P - phase]);
        phase_n     = (phase == LAST_P) ? '0 : phase + 1'b1;
        frame_ok_n  = (phase == LAST_P) && !frame_bad && !mismatch;
        frame_bad_n = (phase == LAST_P) ? 1'b0 : (frame_bad | mismatch);
        if (mismatch) begin
          bit_err_n = 1'b1;
          consec_n  = consec + 1'b1;
          if (consec_n == THRESH) begin
            state_n  = HUNT;
            fill_n   = '0;
            sr_n     = '0;
            consec_n = '0;
          end
        end else begin
          consec_n = '0;
        end
      end

      default: state_n = HUNT;
    endcase
  end

  assign locked = (state == LOCKED);

  sat_counter #(
    .W   (ERR_W),
    .MAX (ERR_MAX)
  ) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_err),
    .inc   (bit_err_n),
    .q     (err_count)
  );

endmodule
